blit_cmd_queue: RTL and testbench
=================================

Name: blit_cmd_queue

Overview:
- Command queue and sequencer in front of the blitter. The CPU-side hwregs push complete blit descriptors into a FIFO.
- The block pops one descriptor at a time and drives the blitter parameter inputs and blit_start. It holds the parameters stable for the whole blit and waits for blit_busy to fall before issuing the next descriptor.
- Clip window and transparent colour are not queued; they stay as static hwregs.

Parameters:
DEPTH, 8, queue entries; power of two, minimum 2.
CNT_W, 4, width of queue_count; equals log2(DEPTH)+1.

Ports:
clock  input  1  system clock
reset  input  1  reset, synchronous, active-high
push_valid  input  1  descriptor present on push_data
push_ready  output  1  queue can accept; equals !full && !flush
push_data  input  204  packed descriptor: [7:0] cmd, [23:8] width, [39:24] height, [47:40] fgcolor, [55:48] bgcolor, [81:56] dest_addr, [97:82] dest_bpr, [113:98] dest_x, [129:114] dest_y, [155:130] src_addr, [171:156] src_bpr, [187:172] src_x, [203:188] src_y
flush  input  1  discard all queued (not yet popped) descriptors
blit_cmd, blit_width, blit_height, blit_fgcolor, blit_bgcolor, blit_dest_addr, blit_dest_bpr, blit_dest_x, blit_dest_y, blit_src_addr, blit_src_bpr, blit_src_x, blit_src_y  output  per field of push_data  registered descriptor fields to the blitter
blit_start  output  1  start request to the blitter
blit_busy  input  1  blitter busy status
queue_count  output  CNT_W  number of queued descriptors; excludes the active blit
seq_busy  output  1  high when the queue is non-empty or state != IDLE
done_pulse  output  1  one-cycle pulse per completed or skipped descriptor
done_count  output  16  completed-descriptor counter; wraps at 0xFFFF->0

Behaviour:
- Reset: FIFO emptied and state=IDLE. These outputs reset to 0: blit_start, done_pulse, done_count, queue_count, seq_busy, and all blit_* parameter outputs.
- Push is accepted on a clock edge when push_valid && push_ready. With push_valid && !push_ready the descriptor is dropped and nothing changes; the source must hold it.
- No bypass: a push into a full queue is refused even when a pop happens in the same cycle.
- Push and pop in the same cycle: count is unchanged.
- flush: queue cleared at the next edge. Any push in the same cycle is lost (push_ready is 0). The active blit is not affected.
- State IDLE, when the queue is non-empty and blit_busy==0:
  - Pop the head and register all fields onto the blit_* outputs.
  - If cmd==0, width==0 or height==0: the descriptor is skipped. No blit_start; done_pulse=1 next cycle; done_count+1; stay in IDLE.
  - Otherwise: blit_start<=1 and go to ACCEPT.
- State ACCEPT: hold blit_start=1 until blit_busy==1 is sampled, because the blitter may be stalled. On that cycle blit_start<=0 and go to RUN.
- State RUN: wait for blit_busy==0. Then done_pulse<=1, done_count+1, and go to IDLE.
  - The next pop may occur in the cycle after the return to IDLE, giving a minimum of 1 idle cycle between blits.
- Latency: a push accepted at edge N into an empty queue in IDLE, with blit_busy=0, gives parameters and blit_start=1 visible after edge N+1.
- blit_* outputs change only on a pop; they hold through ACCEPT, RUN and IDLE until the next pop.
- Reset mid-operation returns everything to the reset values. The blitter shares the same reset.
- queue_count updates at the edge after push, pop or flush.

Test Plan:
- Reset, then push one FILL descriptor (cmd=1, w=4, h=2, fg=0x3C) with blit_busy low → after edge N+1, blit_start=1 and blit_width=4. Model busy high 1 cycle later → start drops; busy low after 8 cycles → done_pulse once, done_count=1.
- Push 3 descriptors back-to-back while the first blit is busy → queue_count=2 during the first blit. Blits are issued strictly in order, each start only after busy falls. done_count=3 at the end.
- Hold blit_busy low for 5 cycles after start (stalled blitter) → blit_start stays 1 for all 5 cycles, parameters are stable, and there is no second pop.
- Fill all DEPTH=8 entries while a blit runs → push_ready=0 and a 9th push_valid is refused. One pop brings push_ready back to 1.
- Push width=0 and cmd=0 descriptors → no blit_start; two done_pulses; done_count+2.
- Flush with 4 queued entries during RUN → queue_count=0 next cycle, the active blit completes with 1 done_pulse, and a push in the flush cycle is lost. Reset during ACCEPT → blit_start=0 and queue empty.

Source files
------------

// File: rtl/blit_cmd_queue.sv
// Descriptor FIFO and sequencer feeding the blitter: a push into an empty idle queue gives params + blit_start after the next edge.
// Backpressure: push_ready drops when full or flushing; blits are issued one at a time, gated by blit_busy.
module blit_cmd_queue #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic [203:0]     push_data,
    input  logic             flush,
    output logic [7:0]       blit_cmd,
    output logic [15:0]      blit_width,
    output logic [15:0]      blit_height,
    output logic [7:0]       blit_fgcolor,
    output logic [7:0]       blit_bgcolor,
    output logic [25:0]      blit_dest_addr,
    output logic [15:0]      blit_dest_bpr,
    output logic [15:0]      blit_dest_x,
    output logic [15:0]      blit_dest_y,
    output logic [25:0]      blit_src_addr,
    output logic [15:0]      blit_src_bpr,
    output logic [15:0]      blit_src_x,
    output logic [15:0]      blit_src_y,
    output logic             blit_start,
    input  logic             blit_busy,
    output logic [CNT_W-1:0] queue_count,
    output logic             seq_busy,
    output logic             done_pulse,
    output logic [15:0]      done_count
);

    localparam int PTR_W  = CNT_W - 1;
    localparam int DESC_W = 204;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEPT = 2'd1,
        RUN    = 2'd2
    } state_t;

    logic [DESC_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;

    state_t            state_q;
    logic [DESC_W-1:0] desc_q;
    logic              blit_start_q;
    logic              done_pulse_q;
    logic [15:0]       done_count_q;
    logic              seq_busy_q;

    logic [DESC_W-1:0] head;
    logic              head_skip;
    logic              empty, full;
    logic              push_fire, pop_fire;
    logic              active_d;

    assign head      = mem_q[rd_ptr_q];
    assign head_skip = (head[7:0] == 8'd0) || (head[23:8] == 16'd0) || (head[39:24] == 16'd0);
    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_W'(DEPTH));

    // No bypass: a full queue refuses a push even if a pop frees a slot this cycle.
    assign push_ready = !full && !flush;
    assign push_fire  = push_valid && push_ready;
    // A flush discards the head too, so it must not be popped in the same cycle.
    assign pop_fire   = (state_q == IDLE) && !empty && !blit_busy && !flush;

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (push_fire && !pop_fire) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_fire && !push_fire) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_comb begin
        active_d = 1'b0;
        case (state_q)
            IDLE:    active_d = pop_fire && !head_skip;
            ACCEPT:  active_d = 1'b1;
            RUN:     active_d = blit_busy;
            default: active_d = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (push_fire) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (push_fire) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (flush) begin
                rd_ptr_q <= wr_ptr_q;
            end else if (pop_fire) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            desc_q       <= '0;
            blit_start_q <= 1'b0;
            done_pulse_q <= 1'b0;
            done_count_q <= '0;
            seq_busy_q   <= 1'b0;
        end else begin
            done_pulse_q <= 1'b0;
            seq_busy_q   <= (count_d != '0) || active_d;
            case (state_q)
                IDLE: begin
                    if (pop_fire) begin
                        desc_q <= head;
                        if (head_skip) begin
                            done_pulse_q <= 1'b1;
                            done_count_q <= done_count_q + 16'd1;
                        end else begin
                            blit_start_q <= 1'b1;
                            state_q      <= ACCEPT;
                        end
                    end
                end
                // The blitter may be stalled; keep requesting until it reports busy.
                ACCEPT: begin
                    if (blit_busy) begin
                        blit_start_q <= 1'b0;
                        state_q      <= RUN;
                    end
                end
                RUN: begin
                    if (!blit_busy) begin
                        done_pulse_q <= 1'b1;
                        done_count_q <= done_count_q + 16'd1;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign blit_cmd       = desc_q[7:0];
    assign blit_width     = desc_q[23:8];
    assign blit_height    = desc_q[39:24];
    assign blit_fgcolor   = desc_q[47:40];
    assign blit_bgcolor   = desc_q[55:48];
    assign blit_dest_addr = desc_q[81:56];
    assign blit_dest_bpr  = desc_q[97:82];
    assign blit_dest_x    = desc_q[113:98];
    assign blit_dest_y    = desc_q[129:114];
    assign blit_src_addr  = desc_q[155:130];
    assign blit_src_bpr   = desc_q[171:156];
    assign blit_src_x     = desc_q[187:172];
    assign blit_src_y     = desc_q[203:188];

    assign blit_start  = blit_start_q;
    assign done_pulse  = done_pulse_q;
    assign done_count  = done_count_q;
    assign queue_count = count_q;
    assign seq_busy    = seq_busy_q;

endmodule

// File: tb/tb_blit_cmd_queue.sv
// Bench for blit_cmd_queue: fixed vectors, directed corner sequences and random traffic against a queue-based model.
module tb_blit_cmd_queue;

    localparam int DEPTH = 8;
    localparam int CNT_W = 4;

    logic             clock = 1'b0;
    logic             reset;
    logic             push_valid;
    logic             push_ready;
    logic [203:0]     push_data;
    logic             flush;
    logic [7:0]       blit_cmd;
    logic [15:0]      blit_width;
    logic [15:0]      blit_height;
    logic [7:0]       blit_fgcolor;
    logic [7:0]       blit_bgcolor;
    logic [25:0]      blit_dest_addr;
    logic [15:0]      blit_dest_bpr;
    logic [15:0]      blit_dest_x;
    logic [15:0]      blit_dest_y;
    logic [25:0]      blit_src_addr;
    logic [15:0]      blit_src_bpr;
    logic [15:0]      blit_src_x;
    logic [15:0]      blit_src_y;
    logic             blit_start;
    logic             blit_busy;
    logic [CNT_W-1:0] queue_count;
    logic             seq_busy;
    logic             done_pulse;
    logic [15:0]      done_count;

    blit_cmd_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset),
        .push_valid(push_valid), .push_ready(push_ready), .push_data(push_data), .flush(flush),
        .blit_cmd(blit_cmd), .blit_width(blit_width), .blit_height(blit_height),
        .blit_fgcolor(blit_fgcolor), .blit_bgcolor(blit_bgcolor),
        .blit_dest_addr(blit_dest_addr), .blit_dest_bpr(blit_dest_bpr),
        .blit_dest_x(blit_dest_x), .blit_dest_y(blit_dest_y),
        .blit_src_addr(blit_src_addr), .blit_src_bpr(blit_src_bpr),
        .blit_src_x(blit_src_x), .blit_src_y(blit_src_y),
        .blit_start(blit_start), .blit_busy(blit_busy),
        .queue_count(queue_count), .seq_busy(seq_busy),
        .done_pulse(done_pulse), .done_count(done_count)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: descriptor queue plus sequencer phase (0 idle, 1 waiting for accept, 2 running).
    logic [203:0] mq[$];
    int           m_phase = 0;
    logic [203:0] m_cur   = '0;
    logic         m_start = 1'b0;
    logic         m_pd    = 1'b0;
    logic [15:0]  m_dc    = '0;

    logic [15:0]  starts[$];
    logic         prev_start = 1'b0;

    wire [203:0] desc_o = {blit_src_y, blit_src_x, blit_src_bpr, blit_src_addr,
                           blit_dest_y, blit_dest_x, blit_dest_bpr, blit_dest_addr,
                           blit_bgcolor, blit_fgcolor, blit_height, blit_width, blit_cmd};

    typedef struct {
        logic             pv;
        logic [7:0]       cmd;
        logic [15:0]      w;
        logic [15:0]      h;
        logic             busy;
        logic             es;
        logic [CNT_W-1:0] eqc;
        logic [15:0]      edc;
        logic             epd;
        logic [15:0]      ew;
    } vec_t;

    vec_t vt[16];

    task automatic chk(input string nm, input logic [203:0] act, input logic [203:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    function automatic logic [203:0] mk(input logic [7:0] c, input logic [15:0] w,
                                        input logic [15:0] h, input logic [15:0] dx);
        return {16'h0011, 16'h0022, 16'h0140, 26'h0ABCDE0, 16'h0033, dx,
                16'h0280, 26'h0123456, 8'h81, 8'h3C, h, w, c};
    endfunction

    function automatic logic [203:0] rnd_desc();
        logic [223:0] r;
        logic [203:0] d;
        r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        d = r[203:0];
        d[7:0]   = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
        d[23:8]  = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 40));
        d[39:24] = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 40));
        return d;
    endfunction

    // Advance the model by one edge using the inputs currently applied.
    task automatic model_step();
        logic pr;
        logic popped;
        if (reset) begin
            mq.delete();
            m_phase = 0;
            m_cur   = '0;
            m_start = 1'b0;
            m_pd    = 1'b0;
            m_dc    = '0;
        end else begin
            pr     = (mq.size() < DEPTH) && !flush;
            popped = 1'b0;
            m_pd   = 1'b0;
            case (m_phase)
                0: if (mq.size() != 0 && !blit_busy && !flush) begin
                    m_cur  = mq[0];
                    popped = 1'b1;
                    if (m_cur[7:0] == 0 || m_cur[23:8] == 0 || m_cur[39:24] == 0) begin
                        m_pd = 1'b1;
                        m_dc = m_dc + 16'd1;
                    end else begin
                        m_start = 1'b1;
                        m_phase = 1;
                    end
                end
                1: if (blit_busy) begin
                    m_start = 1'b0;
                    m_phase = 2;
                end
                default: if (!blit_busy) begin
                    m_pd    = 1'b1;
                    m_dc    = m_dc + 16'd1;
                    m_phase = 0;
                end
            endcase
            if (flush) begin
                mq.delete();
            end else begin
                if (popped) void'(mq.pop_front());
                if (push_valid && pr) mq.push_back(push_data);
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
        chk("queue_count", 204'(queue_count), 204'(mq.size()));
        chk("push_ready", 204'(push_ready), 204'((mq.size() < DEPTH) && !flush));
        chk("blit_start", 204'(blit_start), 204'(m_start));
        chk("done_pulse", 204'(done_pulse), 204'(m_pd));
        chk("done_count", 204'(done_count), 204'(m_dc));
        chk("seq_busy", 204'(seq_busy), 204'((mq.size() != 0) || (m_phase != 0)));
        chk("blit_desc", desc_o, m_cur);
        if (blit_start === 1'b1 && prev_start !== 1'b1) starts.push_back(blit_dest_x);
        prev_start = blit_start;
    endtask

    task automatic drain(input int max_cyc);
        int n;
        n = 0;
        push_valid = 1'b0;
        flush      = 1'b0;
        while ((mq.size() != 0 || m_phase != 0) && n < max_cyc) begin
            case (m_phase)
                0:       blit_busy = 1'b0;
                1:       blit_busy = ($urandom_range(0, 2) != 0);
                default: blit_busy = ($urandom_range(0, 3) != 0);
            endcase
            tick();
            n++;
        end
        chk("drain_in_time", 204'(n < max_cyc), 204'(1));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] dc_before;

        reset = 1'b1; push_valid = 1'b0; push_data = '0; flush = 1'b0; blit_busy = 1'b0;
        tick();
        tick();
        chk("reset_start", 204'(blit_start), 204'(0));
        chk("reset_qc", 204'(queue_count), 204'(0));
        chk("reset_dc", 204'(done_count), 204'(0));
        reset = 1'b0;

        // Single FILL blit, then two skipped descriptors (width 0, cmd 0).
        vt[0]  = '{1'b1, 8'd1, 16'd4, 16'd2, 1'b0, 1'b0, 4'd1, 16'd0, 1'b0, 16'd0};
        vt[1]  = '{1'b0, 8'd0, 16'd0, 16'd0, 1'b0, 1'b1, 4'd0, 16'd0, 1'b0, 16'd4};
        for (int i = 2; i < 10; i++)
            vt[i] = '{1'b0, 8'd0, 16'd0, 16'd0, 1'b1, 1'b0, 4'd0, 16'd0, 1'b0, 16'd4};
        vt[10] = '{1'b0, 8'd0, 16'd0, 16'd0, 1'b0, 1'b0, 4'd0, 16'd1, 1'b1, 16'd4};
        vt[11] = '{1'b0, 8'd0, 16'd0, 16'd0, 1'b0, 1'b0, 4'd0, 16'd1, 1'b0, 16'd4};
        vt[12] = '{1'b1, 8'd1, 16'd0, 16'd5, 1'b0, 1'b0, 4'd1, 16'd1, 1'b0, 16'd4};
        vt[13] = '{1'b1, 8'd0, 16'd3, 16'd3, 1'b0, 1'b0, 4'd1, 16'd2, 1'b1, 16'd0};
        vt[14] = '{1'b0, 8'd0, 16'd0, 16'd0, 1'b0, 1'b0, 4'd0, 16'd3, 1'b1, 16'd3};
        vt[15] = '{1'b0, 8'd0, 16'd0, 16'd0, 1'b0, 1'b0, 4'd0, 16'd3, 1'b0, 16'd3};
        for (int i = 0; i < 16; i++) begin
            push_valid = vt[i].pv;
            push_data  = mk(vt[i].cmd, vt[i].w, vt[i].h, 16'(i));
            blit_busy  = vt[i].busy;
            tick();
            chk($sformatf("tbl%0d_start", i), 204'(blit_start), 204'(vt[i].es));
            chk($sformatf("tbl%0d_qc", i), 204'(queue_count), 204'(vt[i].eqc));
            chk($sformatf("tbl%0d_dc", i), 204'(done_count), 204'(vt[i].edc));
            chk($sformatf("tbl%0d_pulse", i), 204'(done_pulse), 204'(vt[i].epd));
            chk($sformatf("tbl%0d_width", i), 204'(blit_width), 204'(vt[i].ew));
        end
        push_valid = 1'b0;

        // Three back-to-back descriptors, issued strictly in order.
        starts.delete();
        push_valid = 1'b1; push_data = mk(8'd2, 16'd5, 16'd5, 16'd1); blit_busy = 1'b0; tick();
        push_data = mk(8'd2, 16'd5, 16'd5, 16'd2); tick();
        push_data = mk(8'd2, 16'd5, 16'd5, 16'd3); blit_busy = 1'b1; tick();
        chk("b2b_qc_during_first", 204'(queue_count), 204'(2));
        push_valid = 1'b0;
        tick();
        tick();
        drain(300);
        chk("b2b_nstarts", 204'(starts.size()), 204'(3));
        for (int i = 0; i < 3; i++)
            chk($sformatf("b2b_order%0d", i), 204'((starts.size() > i) ? starts[i] : 16'hFFFF), 204'(i + 1));
        chk("b2b_done_count", 204'(done_count), 204'(6));

        // Stalled blitter: start held, parameters stable, no second pop.
        push_valid = 1'b1; push_data = mk(8'd3, 16'd2, 16'd2, 16'd7); blit_busy = 1'b0; tick();
        push_data = mk(8'd3, 16'd2, 16'd2, 16'd8); tick();
        push_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("stall%0d_start", i), 204'(blit_start), 204'(1));
            chk($sformatf("stall%0d_qc", i), 204'(queue_count), 204'(1));
            chk($sformatf("stall%0d_dx", i), 204'(blit_dest_x), 204'(7));
        end
        blit_busy = 1'b1; tick();
        chk("stall_start_drop", 204'(blit_start), 204'(0));
        drain(300);

        // Fill all entries during a blit; the ninth push is refused, including on the pop cycle.
        push_valid = 1'b1; push_data = mk(8'd1, 16'd1, 16'd1, 16'd20); blit_busy = 1'b0; tick();
        push_valid = 1'b0; tick();
        blit_busy = 1'b1; tick();
        for (int i = 0; i < DEPTH; i++) begin
            push_valid = 1'b1; push_data = mk(8'd1, 16'd1, 16'd1, 16'(30 + i)); tick();
        end
        chk("full_qc", 204'(queue_count), 204'(DEPTH));
        chk("full_ready", 204'(push_ready), 204'(0));
        push_data = mk(8'd1, 16'd1, 16'd1, 16'd99); tick();
        chk("full_ninth_refused", 204'(queue_count), 204'(DEPTH));
        blit_busy = 1'b0; tick();
        tick();
        chk("full_pop_qc", 204'(queue_count), 204'(DEPTH - 1));
        chk("full_pop_ready", 204'(push_ready), 204'(1));
        push_valid = 1'b0;
        drain(500);

        // Flush during RUN with four queued entries and a push in the flush cycle.
        push_valid = 1'b1; push_data = mk(8'd4, 16'd3, 16'd3, 16'd40); blit_busy = 1'b0; tick();
        push_valid = 1'b0; tick();
        blit_busy = 1'b1; tick();
        for (int i = 0; i < 4; i++) begin
            push_valid = 1'b1; push_data = mk(8'd4, 16'd3, 16'd3, 16'(41 + i)); tick();
        end
        chk("flush_pre_qc", 204'(queue_count), 204'(4));
        flush = 1'b1; push_data = mk(8'd4, 16'd3, 16'd3, 16'd50);
        #1;
        chk("flush_ready_low", 204'(push_ready), 204'(0));
        dc_before = m_dc;
        tick();
        flush = 1'b0; push_valid = 1'b0;
        chk("flush_qc", 204'(queue_count), 204'(0));
        tick();
        blit_busy = 1'b0; tick();
        chk("flush_active_done", 204'(done_pulse), 204'(1));
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("flush_idle%0d_start", i), 204'(blit_start), 204'(0));
            chk($sformatf("flush_idle%0d_qc", i), 204'(queue_count), 204'(0));
        end
        chk("flush_done_count", 204'(done_count), 204'(dc_before + 16'd1));

        // Reset while waiting for the blitter to accept.
        push_valid = 1'b1; push_data = mk(8'd5, 16'd6, 16'd6, 16'd60); blit_busy = 1'b0; tick();
        push_data = mk(8'd5, 16'd6, 16'd6, 16'd61); tick();
        chk("accept_start", 204'(blit_start), 204'(1));
        push_valid = 1'b0; reset = 1'b1; tick();
        chk("rst_accept_start", 204'(blit_start), 204'(0));
        chk("rst_accept_qc", 204'(queue_count), 204'(0));
        chk("rst_accept_seq_busy", 204'(seq_busy), 204'(0));
        chk("rst_accept_width", 204'(blit_width), 204'(0));
        reset = 1'b0; tick();

        // Random traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            push_valid = 1'($urandom_range(0, 1));
            push_data  = rnd_desc();
            flush      = ($urandom_range(0, 39) == 0);
            case (m_phase)
                0:       blit_busy = ($urandom_range(0, 7) == 0);
                1:       blit_busy = ($urandom_range(0, 2) != 0);
                default: blit_busy = ($urandom_range(0, 3) != 0);
            endcase
            tick();
        end
        drain(500);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
